// File: rtl/mips_pkg.sv
// Shared decode constants for the MIPS ID stage.
// Contents: opcode and funct encodings, ALU operation codes, the control
// bundle carried into ID/EX, and the all-zero bubble value.
package mips_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7
    } alu_op_e;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
    } ctrl_t;

    // A bubble carries no side effects: every control bit low.
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/instruction_decode_register_file.sv
// register_file: NUM_REGS x DATA_W architectural register file.
// Ports:
//   clk, rst_n            clock, synchronous active-low clear of all entries
//   i_wb_en/addr/data     single write port (from WB)
//   i_rs_addr, i_rt_addr  two asynchronous read addresses
//   o_rs_data, o_rt_data  read data; r0 reads 0, same-cycle WB write is bypassed
module register_file #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wb_en,
    input  logic [REG_ADDR_W-1:0] i_wb_addr,
    input  logic [DATA_W-1:0]     i_wb_data,
    input  logic [REG_ADDR_W-1:0] i_rs_addr,
    input  logic [REG_ADDR_W-1:0] i_rt_addr,
    output logic [DATA_W-1:0]     o_rs_data,
    output logic [DATA_W-1:0]     o_rt_data
);

    logic [DATA_W-1:0] r_mem [NUM_REGS];
    logic              w_wr;

    assign w_wr = i_wb_en && (i_wb_addr != '0);

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
        end else if (w_wr) begin
            r_mem[i_wb_addr] <= i_wb_data;
        end
    end

    // Write-through: a value being written this cycle is visible to ID now,
    // so WB and ID can overlap without an extra hazard cycle.
    always_comb begin
        o_rs_data = '0;
        o_rt_data = '0;
        if (i_rs_addr != '0)
            o_rs_data = (w_wr && i_wb_addr == i_rs_addr) ? i_wb_data : r_mem[i_rs_addr];
        if (i_rt_addr != '0)
            o_rt_data = (w_wr && i_wb_addr == i_rt_addr) ? i_wb_data : r_mem[i_rt_addr];
    end

endmodule

// File: rtl/instruction_decode.sv
// instruction_decode: ID stage of the 5-stage MIPS pipeline.
// Decodes instr, reads the register file, extends the immediate, detects
// load-use hazards and registers everything into ID/EX (1-cycle latency).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   instr, pc_in               instruction and its pc from fetch
//   flush                      squash the instruction currently in ID
//   wb_en, wb_addr, wb_data    register-file write from WB
//   stall                      combinational load-use stall to fetch
//   ex_*                       ID/EX pipeline register outputs
// Optional: DECODE_ILLEGAL_TRAP_EN adds ex_illegal, a one-cycle flag for an
// unknown encoding that actually reached issue (not flushed or stalled).
module instruction_decode
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           instr,
    input  logic [DATA_W-1:0]     pc_in,
    input  logic                  flush,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  stall,
    output logic [DATA_W-1:0]     ex_pc,
    output logic [DATA_W-1:0]     ex_rs_data,
    output logic [DATA_W-1:0]     ex_rt_data,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_dst,
    output logic [3:0]            ex_alu_op,
    output logic                  ex_alu_src,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_reg_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_branch,
    output logic                  ex_jump,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic                  ex_illegal,
`endif
    output logic [25:0]           ex_jump_target
);

    // Instruction fields
    logic [5:0]            w_op;
    logic [5:0]            w_funct;
    logic [REG_ADDR_W-1:0] w_rs, w_rt, w_rd;
    logic [DATA_W-1:0]     w_sext, w_zext;

    assign w_op    = instr[31:26];
    assign w_funct = instr[5:0];
    assign w_rs    = instr[25:21];
    assign w_rt    = instr[20:16];
    assign w_rd    = instr[15:11];
    assign w_sext  = {{(DATA_W-16){instr[15]}}, instr[15:0]};
    assign w_zext  = {{(DATA_W-16){1'b0}}, instr[15:0]};

    // Register file
    logic [DATA_W-1:0] w_rs_data, w_rt_data;

    register_file #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_REGS   (NUM_REGS)
    ) u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wb_en   (wb_en),
        .i_wb_addr (wb_addr),
        .i_wb_data (wb_data),
        .i_rs_addr (w_rs),
        .i_rt_addr (w_rt),
        .o_rs_data (w_rs_data),
        .o_rt_data (w_rt_data)
    );

    // Decoder
    ctrl_t                 w_ctrl;
    logic [REG_ADDR_W-1:0] w_dst;
    logic [DATA_W-1:0]     w_imm;
    logic                  w_legal;
    logic                  w_uses_rt;

    always_comb begin
        w_ctrl    = CTRL_BUBBLE;
        w_dst     = '0;
        w_imm     = w_sext;
        w_legal   = 1'b1;
        w_uses_rt = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                w_uses_rt        = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_dst            = w_rd;
                case (w_funct)
                    FN_ADD:  w_ctrl.alu_op = ALU_ADD;
                    FN_SUB:  w_ctrl.alu_op = ALU_SUB;
                    FN_AND:  w_ctrl.alu_op = ALU_AND;
                    FN_OR:   w_ctrl.alu_op = ALU_OR;
                    FN_SLT:  w_ctrl.alu_op = ALU_SLT;
                    default: w_legal = 1'b0;
                endcase
            end
            OP_ADDI: begin
                w_ctrl.alu_op    = ALU_ADD;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_dst            = w_rt;
            end
            OP_ANDI, OP_ORI: begin
                w_ctrl.alu_op    = (w_op == OP_ANDI) ? ALU_AND : ALU_OR;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_dst            = w_rt;
                w_imm            = w_zext;
            end
            OP_LW: begin
                w_ctrl.alu_op     = ALU_ADD;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_write  = 1'b1;
                w_dst             = w_rt;
            end
            OP_SW: begin
                w_uses_rt        = 1'b1;
                w_ctrl.alu_op    = ALU_ADD;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.mem_write = 1'b1;
            end
            OP_BEQ: begin
                w_uses_rt     = 1'b1;
                w_ctrl.alu_op = ALU_SUB;
                w_ctrl.branch = 1'b1;
            end
            OP_J: begin
                w_ctrl.jump = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // ID/EX register
    logic [DATA_W-1:0]     r_ex_pc, r_ex_rs_data, r_ex_rt_data, r_ex_imm;
    logic [REG_ADDR_W-1:0] r_ex_rs, r_ex_rt, r_ex_dst;
    ctrl_t                 r_ex_ctrl;
    logic [25:0]           r_ex_jump_target;

    // Load-use: the load in EX produces its value too late for this
    // instruction. A flushed instruction is dead, so it never stalls.
    logic w_stall;
    logic w_issue;

    assign w_stall = r_ex_ctrl.mem_read && (r_ex_rt != '0) &&
                     ((r_ex_rt == w_rs) || ((r_ex_rt == w_rt) && w_uses_rt)) &&
                     !flush;
    assign w_issue = w_legal && !flush && !w_stall;
    assign stall   = w_stall;

    // Anything that does not issue becomes a fully zeroed bubble.
    always_ff @(posedge clk) begin
        if (!rst_n || !w_issue) begin
            r_ex_pc          <= '0;
            r_ex_rs_data     <= '0;
            r_ex_rt_data     <= '0;
            r_ex_imm         <= '0;
            r_ex_rs          <= '0;
            r_ex_rt          <= '0;
            r_ex_dst         <= '0;
            r_ex_ctrl        <= CTRL_BUBBLE;
            r_ex_jump_target <= '0;
        end else begin
            r_ex_pc          <= pc_in;
            r_ex_rs_data     <= w_rs_data;
            r_ex_rt_data     <= w_rt_data;
            r_ex_imm         <= w_imm;
            r_ex_rs          <= w_rs;
            r_ex_rt          <= w_rt;
            r_ex_dst         <= w_dst;
            r_ex_ctrl        <= w_ctrl;
            r_ex_jump_target <= instr[25:0];
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic r_ex_illegal;

    always_ff @(posedge clk) begin
        if (!rst_n) r_ex_illegal <= 1'b0;
        else        r_ex_illegal <= !w_legal && !flush && !w_stall;
    end

    assign ex_illegal = r_ex_illegal;
`endif

    assign ex_pc          = r_ex_pc;
    assign ex_rs_data     = r_ex_rs_data;
    assign ex_rt_data     = r_ex_rt_data;
    assign ex_imm         = r_ex_imm;
    assign ex_rs          = r_ex_rs;
    assign ex_rt          = r_ex_rt;
    assign ex_dst         = r_ex_dst;
    assign ex_alu_op      = r_ex_ctrl.alu_op;
    assign ex_alu_src     = r_ex_ctrl.alu_src;
    assign ex_mem_read    = r_ex_ctrl.mem_read;
    assign ex_mem_write   = r_ex_ctrl.mem_write;
    assign ex_reg_write   = r_ex_ctrl.reg_write;
    assign ex_mem_to_reg  = r_ex_ctrl.mem_to_reg;
    assign ex_branch      = r_ex_ctrl.branch;
    assign ex_jump        = r_ex_ctrl.jump;
    assign ex_jump_target = r_ex_jump_target;

endmodule

// File: tb/tb_instruction_decode.sv
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr, pc_in, wb_data;
    logic        flush, wb_en;
    logic [4:0]  wb_addr;
    logic        stall;
    logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_dst;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write;
    logic        ex_mem_to_reg, ex_branch, ex_jump;
    logic [25:0] ex_jump_target;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        ex_illegal;
`endif

    always #5 clk = ~clk;

    instruction_decode dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .pc_in(pc_in), .flush(flush),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall),
        .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_jump(ex_jump),
`ifdef DECODE_ILLEGAL_TRAP_EN
        .ex_illegal(ex_illegal),
`endif
        .ex_jump_target(ex_jump_target)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] pc, rsd, rtd, imm;
        logic [4:0]  rs, rt, dst;
        logic [3:0]  alu;
        logic        src, mr, mw, rw, m2r, br, jmp;
        logic [25:0] jt;
        logic        imm_ok;
    } ex_t;

    logic [31:0] regs [32];
    ex_t         m;
    logic        m_ill;
    logic        m_st;
    logic        dut_st;

    function automatic logic [31:0] rd(input logic [4:0] a, input logic we,
                                       input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (we && wa == a) return wd;
        return regs[a];
    endfunction

    // Architectural meaning of each mnemonic; legal=0 for anything else.
    function automatic ex_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] a, input logic [31:0] b,
                                       output logic legal);
        ex_t e;
        logic [5:0] op;
        op = ins[31:26];
        e = '0;
        legal = 1'b1;
        e.pc = pc; e.rs = ins[25:21]; e.rt = ins[20:16]; e.rsd = a; e.rtd = b;
        e.jt = ins[25:0]; e.imm = {{16{ins[15]}}, ins[15:0]}; e.imm_ok = 1'b1;
        if (op == 6'h00) begin
            e.imm_ok = 1'b0; e.rw = 1'b1; e.dst = ins[15:11];
            case (ins[5:0])
                6'h20: e.alu = 4'd2;
                6'h22: e.alu = 4'd6;
                6'h24: e.alu = 4'd0;
                6'h25: e.alu = 4'd1;
                6'h2A: e.alu = 4'd7;
                default: legal = 1'b0;
            endcase
        end else begin
            case (op)
                6'h08: begin e.alu = 4'd2; e.src = 1'b1; e.rw = 1'b1; e.dst = e.rt; end
                6'h0C: begin e.alu = 4'd0; e.src = 1'b1; e.rw = 1'b1; e.dst = e.rt;
                             e.imm = {16'h0, ins[15:0]}; end
                6'h0D: begin e.alu = 4'd1; e.src = 1'b1; e.rw = 1'b1; e.dst = e.rt;
                             e.imm = {16'h0, ins[15:0]}; end
                6'h23: begin e.alu = 4'd2; e.src = 1'b1; e.mr = 1'b1; e.m2r = 1'b1;
                             e.rw = 1'b1; e.dst = e.rt; end
                6'h2B: begin e.alu = 4'd2; e.src = 1'b1; e.mw = 1'b1; end
                6'h04: begin e.alu = 4'd6; e.br = 1'b1; end
                6'h02: begin e.jmp = 1'b1; e.imm_ok = 1'b0; end
                default: legal = 1'b0;
            endcase
        end
        return e;
    endfunction

    function automatic logic ref_stall(input logic [31:0] ins, input logic fl);
        logic [5:0] op;
        logic reads_rt;
        op = ins[31:26];
        reads_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
        return m.mr && (m.rt != 5'd0) && !fl &&
               ((m.rt == ins[25:21]) || (reads_rt && m.rt == ins[20:16]));
    endfunction

    task automatic cmp_ex(input string tag);
        chk({tag, ":ex_pc"},       ex_pc, m.pc);
        chk({tag, ":ex_rs_data"},  ex_rs_data, m.rsd);
        chk({tag, ":ex_rt_data"},  ex_rt_data, m.rtd);
        if (m.imm_ok) chk({tag, ":ex_imm"}, ex_imm, m.imm);
        chk({tag, ":ex_rs"},       32'(ex_rs), 32'(m.rs));
        chk({tag, ":ex_rt"},       32'(ex_rt), 32'(m.rt));
        chk({tag, ":ex_dst"},      32'(ex_dst), 32'(m.dst));
        chk({tag, ":ex_alu_op"},   32'(ex_alu_op), 32'(m.alu));
        chk({tag, ":ctrl"},
            32'({ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch, ex_jump}),
            32'({m.src, m.mr, m.mw, m.rw, m.m2r, m.br, m.jmp}));
        chk({tag, ":ex_jump_target"}, 32'(ex_jump_target), 32'(m.jt));
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk({tag, ":ex_illegal"}, 32'(ex_illegal), 32'(m_ill));
`endif
    endtask

    // One cycle: drive at negedge, check stall before the edge, ID/EX after.
    task automatic step(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                        input logic fl, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic rst);
        ex_t  nx;
        logic legal, st, ill;
        @(negedge clk);
        instr = ins; pc_in = pc; flush = fl; wb_en = we; wb_addr = wa; wb_data = wd;
        rst_n = ~rst;
        #1;
        st = ref_stall(ins, fl);
        dut_st = stall;
        chk({tag, ":stall"}, 32'(stall), 32'(st));
        nx  = ref_decode(ins, pc, rd(ins[25:21], we, wa, wd), rd(ins[20:16], we, wa, wd), legal);
        ill = !rst && !legal && !fl && !st;
        if (rst || fl || st || !legal) begin
            nx = '0;
            nx.imm_ok = 1'b1;
        end
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        end else if (we && wa != 5'd0) begin
            regs[wa] = wd;
        end
        @(posedge clk);
        #1;
        m = nx; m_ill = ill; m_st = st;
        cmp_ex(tag);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [31:0] ins;
        logic        fl, we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        st;
        logic [4:0]  rs, dst;
        logic [3:0]  alu;
        logic        src, rw, mr;
        logic [31:0] imm;
        logic        imm_ok;
        logic [31:0] rsd, rtd;
    } vec_t;

    vec_t tv [11];

    initial begin
        logic [31:0] ins, prev_ins, pc, prev_pc;
        logic [5:0]  fn;
        logic [4:0]  rs, rt, rdst;
        int          k;

        tv[0]  = '{32'h2001FFFF, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd1,  4'd2, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h0};
        tv[1]  = '{32'h3402FFFF, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd2,  4'd1, 1'b1, 1'b1, 1'b0, 32'h0000FFFF, 1'b1, 32'h0, 32'h0};
        tv[2]  = '{32'h00A03020, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd6,  4'd2, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 32'h0};
        tv[3]  = '{32'h00053820, 1'b0, 1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0, 5'd7,  4'd2, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'hDEADBEEF};
        tv[4]  = '{32'h00004820, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9,  4'd2, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
        tv[5]  = '{32'h8D280004, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd9, 5'd8,  4'd2, 1'b1, 1'b1, 1'b1, 32'h4, 1'b1, 32'h0, 32'h0};
        tv[6]  = '{32'h010B5020, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd0,  4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h0};
        tv[7]  = '{32'h010B5020, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd8, 5'd10, 4'd2, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
        tv[8]  = '{32'h8D280004, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd9, 5'd8,  4'd2, 1'b1, 1'b1, 1'b1, 32'h4, 1'b1, 32'h0, 32'h0};
        tv[9]  = '{32'h010B5020, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0,  4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h0};
        tv[10] = '{32'h010B5020, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd8, 5'd10, 4'd2, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};

        instr = 32'h0; pc_in = 32'h0; flush = 1'b0; wb_en = 1'b0; wb_addr = 5'd0;
        wb_data = 32'h0; rst_n = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        m = '0; m_ill = 1'b0; m_st = 1'b0;

        // Reset state
        step("reset", 32'h8D280004, 32'h40, 1'b0, 1'b1, 5'd3, 32'h55, 1'b1);
        chk("reset:ex_mem_read", 32'(ex_mem_read), 32'd0);
        chk("reset:stall", 32'(stall), 32'd0);

        // Table-driven directed vectors
        for (int i = 0; i < 11; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            step(t, tv[i].ins, 32'h100 + 32'(4 * i), tv[i].fl, tv[i].we, tv[i].wa, tv[i].wd, 1'b0);
            chk({t, ":tbl_stall"}, 32'(dut_st), 32'(tv[i].st));
            chk({t, ":tbl_rs"},    32'(ex_rs), 32'(tv[i].rs));
            chk({t, ":tbl_dst"},   32'(ex_dst), 32'(tv[i].dst));
            chk({t, ":tbl_alu"},   32'(ex_alu_op), 32'(tv[i].alu));
            chk({t, ":tbl_ctl"},   32'({ex_alu_src, ex_reg_write, ex_mem_read}),
                                   32'({tv[i].src, tv[i].rw, tv[i].mr}));
            if (tv[i].imm_ok) chk({t, ":tbl_imm"}, ex_imm, tv[i].imm);
            chk({t, ":tbl_rsd"},   ex_rs_data, tv[i].rsd);
            chk({t, ":tbl_rtd"},   ex_rt_data, tv[i].rtd);
        end

        // Jump: target field carried through
        step("jump", 32'h08000123, 32'h200, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        chk("jump:ex_jump", 32'(ex_jump), 32'd1);
        chk("jump:target", 32'(ex_jump_target), 32'h123);

        // Illegal encoding becomes a bubble (and flags when the trap is built in)
        step("illegal", 32'hFC000000, 32'h204, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        chk("illegal:ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_src}), 32'd0);
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk("illegal:flag", 32'(ex_illegal), 32'd1);
        step("illegal_next", 32'h00004820, 32'h208, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        chk("illegal:flag_clear", 32'(ex_illegal), 32'd0);
`endif

        // Reset in the middle of a load-use stall; r5 must be cleared
        step("rst_lw", 32'h8D280004, 32'h300, 1'b0, 1'b1, 5'd5, 32'hCAFEF00D, 1'b0);
        step("rst_hz", 32'h010B5020, 32'h304, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
        chk("rst_hz:stall_before", 32'(dut_st), 32'd1);
        chk("rst_hz:stall_after", 32'(stall), 32'd0);
        chk("rst_hz:ex_pc", ex_pc, 32'd0);
        step("rst_r5", 32'h00053820, 32'h308, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        chk("rst_r5:rt_data", ex_rt_data, 32'd0);

        // Randomized traffic against the model
        prev_ins = 32'h0; prev_pc = 32'h0;
        for (int n = 0; n < 600; n++) begin
            rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
            rdst = 5'($urandom_range(0, 7));
            k = $urandom_range(0, 10);
            case (k)
                0, 1: begin
                    case ($urandom_range(0, 5))
                        0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24;
                        3: fn = 6'h25; 4: fn = 6'h2A; default: fn = 6'($urandom);
                    endcase
                    ins = {6'h00, rs, rt, rdst, 5'd0, fn};
                end
                2: ins = {6'h08, rs, rt, 16'($urandom)};
                3: ins = {6'h0C, rs, rt, 16'($urandom)};
                4: ins = {6'h0D, rs, rt, 16'($urandom)};
                5, 6: ins = {6'h23, rs, rt, 16'($urandom)};
                7: ins = {6'h2B, rs, rt, 16'($urandom)};
                8: ins = {6'h04, rs, rt, 16'($urandom)};
                9: ins = {6'h02, 26'($urandom)};
                default: ins = $urandom;
            endcase
            pc = $urandom & 32'hFFFFFFFC;
            // Fetch holds while stalled: re-present the same instruction
            if (m_st) begin ins = prev_ins; pc = prev_pc; end
            prev_ins = ins; prev_pc = pc;
            step("rand", ins, pc, ($urandom_range(0, 9) == 0), 1'($urandom),
                 5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 99) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
ID stage of the 5-stage MIPS pipeline, directly downstream of instruction_fetch. It consumes instr/pc_out and decodes the opcode and funct fields. It also reads the 32x32 register file, which is written back from WB, and extends the immediate. It detects load-use hazards and raises stall back to instruction_fetch. All results are registered into the ID/EX pipeline register, which feeds the execute stage.

Parameters:
DATA_W, 32, datapath width
REG_ADDR_W, 5, register index width
NUM_REGS, 32, register file depth (2**REG_ADDR_W)

Ports:
clk  in  1  system clock, all state on posedge
rst_n  in  1  reset; synchronous, active-low
instr  in  32  instruction from instruction_fetch
pc_in  in  32  pc_out of instruction_fetch, aligned with instr
flush  in  1  branch/jump taken in EX; squash the current ID instruction
wb_en  in  1  register-file write enable from WB
wb_addr  in  5  write-back destination
wb_data  in  32  write-back data
stall  out  1  combinational; to instruction_fetch stall input
ex_pc  out  32  registered pc_in
ex_rs_data, ex_rt_data  out  32 each  registered operands
ex_imm  out  32  registered extended immediate
ex_rs, ex_rt, ex_dst  out  5 each  source and destination register indices
ex_alu_op  out  4  ALU operation: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT
ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch, ex_jump  out  1 each  control bits
ex_jump_target  out  26  instr[25:0]

Behaviour:
- Reset (rst_n=0 at posedge): all ex_* outputs = 0 and all registers = 0. Reset mid-operation discards the in-flight instruction. stall is 0 while ex_mem_read = 0.
- Latency: 1 cycle. Decode of instr at edge N appears on ex_* after edge N.
- Decode table:
  - R-type (op 0x00), funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A: reg_write=1, dst=rd, alu_src=0.
  - addi 0x08: sign-extend, ADD.
  - andi 0x0C and ori 0x0D: zero-extend, AND/OR.
  - lw 0x23: mem_read=1, mem_to_reg=1, reg_write=1, dst=rt, ADD, sign-extend.
  - sw 0x2B: mem_write=1, ADD, sign-extend.
  - beq 0x04: branch=1, SUB, alu_src=0, sign-extend.
  - j 0x02: jump=1.
  - Unknown opcode or funct: bubble.
- Bubble: all control bits 0 and ex_dst = 0. Data fields are don't-care but are driven 0.
- Register file:
  - Synchronous write at posedge when wb_en=1 and wb_addr!=0. A write to r0 is ignored, and r0 always reads 0.
  - Asynchronous read with write-through bypass: when wb_en=1 and wb_addr==rs (or rt) and the address is nonzero, read data = wb_data in the same cycle.
- Load-use hazard:
  - stall = ex_mem_read & (ex_rt!=0) & (ex_rt==instr.rs | (ex_rt==instr.rt & instruction uses rt)).
  - Instructions that use rt: R-type, sw, beq.
  - While stall=1, ID/EX loads a bubble. The fetch stage holds, so instr is re-presented next cycle.
- flush: ID/EX loads a bubble. stall is forced to 0 because the instruction is dead. flush has priority over stall.
- Simultaneous WB write and hazard: the write completes regardless of stall or flush.

Optional Feature:
DECODE_ILLEGAL_TRAP_EN
- Defined: adds output ex_illegal (1 bit), registered. It is set for one cycle when an unknown opcode or funct is decoded and neither flush nor stall is active. The instruction is still issued as a bubble.
- Undefined: the port is absent and unknown encodings silently become bubbles.

Decomposition:
- Package mips_pkg holds:
  - opcode and funct localparams
  - ALU op encodings
  - the bubble control value
- One natural sub-module, register_file: 32x32, two read ports, one write port, r0 forced to zero, bypass logic. The decoder and hazard logic stay in instruction_decode.

Test Plan:
- Immediate extension: instr 0x2001FFFF (addi $1,$0,-1) -> next cycle ex_imm=0xFFFFFFFF, ex_alu_src=1, ex_reg_write=1, ex_dst=1, ex_alu_op=2. Then instr 0x3402FFFF (ori) -> ex_imm=0x0000FFFF, ex_alu_op=1.
- Write-through bypass and r0: wb_en=1, wb_addr=5, wb_data=0xDEADBEEF in the same cycle as instr 0x00A03020 (add $6,$5,$0) -> ex_rs_data=0xDEADBEEF, ex_rt_data=0, ex_dst=6. Then wb_addr=0, wb_data=0x1234 -> a later read of r0 gives 0.
- Load-use stall: 0x8D280004 (lw $8,4($9)) followed by 0x010B5020 (add $10,$8,$11) -> stall=1 for exactly one cycle and ex_* shows a bubble. The add issues on the next cycle with ex_rs=8.
- Flush priority: a load-use pair as above with flush=1 in the hazard cycle -> stall=0 and ex_* is a bubble.
- Illegal encoding (with DECODE_ILLEGAL_TRAP_EN): instr 0xFC000000 -> all control bits 0 and ex_illegal=1 for one cycle.
- Reset mid-stream: rst_n=0 for one edge during a stall -> all ex_*=0 and stall=0. Register r5 reads 0 afterwards.
